// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: shares one Avalon-style slave port between m0 (fetch) and m1 (load/store),
// holding each grant until the write is accepted or the read data has been returned.
module mips_bus_arbiter #(
   parameter int RD_LAT    = 1,
   parameter bit FAIR_MODE = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_byteenable,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_byteenable,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   output logic [3:0]  s_byteenable,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata
);
   typedef enum logic [1:0] {IDLE, BUSY, RDWAIT} state_t;
   state_t      r_state, w_next;
   logic        r_owner, r_last;
   logic [1:0]  r_lat_cnt;
   logic        w_m0_req, w_m1_req, w_gnt, w_own_req, w_own_wr, w_own_rd, w_busy, w_done;
   assign w_m0_req  = m0_read | m0_write;
   assign w_m1_req  = m1_read | m1_write;
   assign w_gnt     = (w_m0_req & w_m1_req) ? (FAIR_MODE & ~r_last) : w_m1_req;
   assign w_own_req = r_owner ? w_m1_req : w_m0_req;
   assign w_own_wr  = r_owner ? m1_write : m0_write;
   assign w_own_rd  = r_owner ? m1_read : m0_read;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_owner   <= 1'b0;
         r_last    <= 1'b1;
         r_lat_cnt <= 2'd0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && (w_m0_req | w_m1_req)) begin
            r_owner <= w_gnt;
            r_last  <= w_gnt;
         end
         if (r_state == BUSY && w_next == RDWAIT)
            r_lat_cnt <= 2'(RD_LAT - 1);
         else if (r_state == RDWAIT && r_lat_cnt != 2'd0)
            r_lat_cnt <= r_lat_cnt - 2'd1;
      end
   end
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE)
         w_next = (w_m0_req | w_m1_req) ? BUSY : IDLE;
      else if (r_state == BUSY)
         w_next = !w_own_req ? IDLE : s_waitrequest ? BUSY : w_own_wr ? IDLE : RDWAIT;
      else
         w_next = (r_lat_cnt == 2'd0) ? IDLE : RDWAIT;
   end
   // Outputs are forced to their idle values while reset is held so no stale read data escapes
   assign w_busy           = (r_state == BUSY) & ~reset;
   assign w_done           = (r_state == RDWAIT) & (r_lat_cnt == 2'd0) & ~reset;
   assign s_address        = w_busy ? (r_owner ? m1_address : m0_address) : 32'd0;
   assign s_writedata      = w_busy ? (r_owner ? m1_writedata : m0_writedata) : 32'd0;
   assign s_byteenable     = w_busy ? (r_owner ? m1_byteenable : m0_byteenable) : 4'd0;
   assign s_write          = w_busy & w_own_wr;
   assign s_read           = w_busy & w_own_rd & ~w_own_wr;
   assign m0_waitrequest   = ~(w_busy & ~r_owner) | s_waitrequest;
   assign m1_waitrequest   = ~(w_busy & r_owner) | s_waitrequest;
   assign m0_readdatavalid = w_done & ~r_owner;
   assign m1_readdatavalid = w_done & r_owner;
   assign m0_readdata      = m0_readdatavalid ? s_readdata : 32'd0;
   assign m1_readdata      = m1_readdatavalid ? s_readdata : 32'd0;
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: three configurations (lat1/fair, lat3/fair, lat1/fixed) checked every cycle
// against a transaction-level model driven by random master/slave/reset activity.
module tb_mips_bus_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata, s_readdata;
   logic        m0_read, m0_write, m1_read, m1_write, s_waitrequest;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_waitrequest [3];
   logic [31:0] m0_readdata [3];
   logic        m0_readdatavalid [3];
   logic        m1_waitrequest [3];
   logic [31:0] m1_readdata [3];
   logic        m1_readdatavalid [3];
   logic [31:0] s_address [3];
   logic        s_read [3];
   logic        s_write [3];
   logic [31:0] s_writedata [3];
   logic [3:0]  s_byteenable [3];
   int n_err = 0, n_chk = 0, cyc = 0;
   int ph [3], own [3], last [3], due [3], n0 [3], nw [3];
   bit counting = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      mips_bus_arbiter #(.RD_LAT(g == 1 ? 3 : 1), .FAIR_MODE(g != 2)) u_dut (
         .clk(clk), .reset(reset),
         .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
         .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
         .m0_waitrequest(m0_waitrequest[g]), .m0_readdata(m0_readdata[g]),
         .m0_readdatavalid(m0_readdatavalid[g]),
         .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
         .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
         .m1_waitrequest(m1_waitrequest[g]), .m1_readdata(m1_readdata[g]),
         .m1_readdatavalid(m1_readdatavalid[g]),
         .s_address(s_address[g]), .s_read(s_read[g]), .s_write(s_write[g]),
         .s_writedata(s_writedata[g]), .s_byteenable(s_byteenable[g]),
         .s_waitrequest(s_waitrequest), .s_readdata(s_readdata)
      );
   end
   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask
   task automatic step();
      logic [31:0] a [2], wd [2], ed [2];
      logic [3:0]  be [2];
      logic        rd [2], wr [2], q [2], ew [2], ev [2];
      logic [69:0] es;
      int          o, lat;
      #2;
      a  = '{m0_address, m1_address};
      wd = '{m0_writedata, m1_writedata};
      be = '{m0_byteenable, m1_byteenable};
      rd = '{m0_read, m1_read};
      wr = '{m0_write, m1_write};
      q  = '{m0_read | m0_write, m1_read | m1_write};
      for (int g = 0; g < 3; g++) begin
         lat = (g == 1) ? 3 : 1;
         o   = own[g];
         ew  = '{1'b1, 1'b1};
         ev  = '{1'b0, 1'b0};
         ed  = '{32'd0, 32'd0};
         es  = '0;
         if (!reset && ph[g] == 1) begin
            es    = {a[o], rd[o] & ~wr[o], wr[o], wd[o], be[o]};
            ew[o] = s_waitrequest;
         end else if (!reset && ph[g] == 2 && cyc == due[g]) begin
            ev[o] = 1'b1;
            ed[o] = s_readdata;
         end
         chk($sformatf("m0_cfg%0d", g), 72'({m0_waitrequest[g], m0_readdatavalid[g], m0_readdata[g]}),
             72'({ew[0], ev[0], ed[0]}));
         chk($sformatf("m1_cfg%0d", g), 72'({m1_waitrequest[g], m1_readdatavalid[g], m1_readdata[g]}),
             72'({ew[1], ev[1], ed[1]}));
         chk($sformatf("slave_cfg%0d", g), 72'({s_address[g], s_read[g], s_write[g], s_writedata[g],
             s_byteenable[g]}), 72'(es));
         if (counting && s_write[g]) begin
            nw[g]++;
            if (s_address[g] == 32'hBFC00000) n0[g]++;
         end
         if (reset) begin
            ph[g]   = 0;
            last[g] = 1;
         end else if (ph[g] == 0) begin
            if (q[0] | q[1]) begin
               own[g]  = (q[0] && q[1]) ? ((g != 2) ? 1 - last[g] : 0) : (q[1] ? 1 : 0);
               last[g] = own[g];
               ph[g]   = 1;
            end
         end else if (ph[g] == 1) begin
            if (!q[o]) ph[g] = 0;
            else if (!s_waitrequest) begin
               if (wr[o]) ph[g] = 0;
               else begin
                  ph[g]  = 2;
                  due[g] = cyc + lat;
               end
            end
         end else if (cyc == due[g]) ph[g] = 0;
      end
      cyc++;
      @(negedge clk);
   endtask
   initial begin
      int r0, r1;
      for (int g = 0; g < 3; g++) begin
         ph[g] = 0; own[g] = 0; last[g] = 1; due[g] = 0; n0[g] = 0; nw[g] = 0;
      end
      reset = 1'b1;
      {m0_read, m0_write, m1_read, m1_write, s_waitrequest} = '0;
      m0_address = 32'hBFC00000; m1_address = 32'hBFC00030;
      m0_writedata = 32'h11; m1_writedata = 32'h4;
      m0_byteenable = 4'hF; m1_byteenable = 4'hF;
      s_readdata = 32'h3C08BFC0;
      repeat (3) step();
      reset = 1'b0;
      m0_write = 1'b1;
      m1_write = 1'b1;
      counting = 1;
      repeat (16) step();
      counting = 0;
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("grants_m0_cfg%0d", g), 72'(n0[g]), (g == 2) ? 72'd8 : 72'd4);
         chk($sformatf("grants_all_cfg%0d", g), 72'(nw[g]), 72'd8);
      end
      repeat (3000) begin
         r0 = int'($urandom % 8);
         r1 = int'($urandom % 8);
         m0_read  = (r0 < 3) || (r0 == 5);
         m0_write = (r0 == 3) || (r0 == 4) || (r0 == 5);
         m1_read  = (r1 < 3) || (r1 == 5);
         m1_write = (r1 == 3) || (r1 == 4) || (r1 == 5);
         m0_address = $urandom; m1_address = $urandom;
         m0_writedata = $urandom; m1_writedata = $urandom;
         m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
         s_waitrequest = ($urandom % 3) == 0;
         s_readdata = $urandom;
         reset = ($urandom % 100) == 0;
         step();
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
